// File: rtl/uart_pkg.sv
// uart_pkg: shared receiver state encoding and data width.
package uart_pkg;
  localparam int UART_DATA_W = 8;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} rx_state_t;
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: 2-flop synchronizer for the serial line, resets to idle-high.
module uart_rx_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);
  logic [1:0] r_ff;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_ff <= 2'b11;
    else r_ff <= {r_ff[0], i_d};
  assign o_q = r_ff[1];
endmodule

// File: rtl/uart_rx.sv
// uart_rx: mid-bit sampling UART receiver with valid/ready byte output.
// Optional even parity checking is enabled by defining UART_RX_PARITY_EN.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_rx,
  output logic [UART_DATA_W-1:0] o_data,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic                   o_frame_err,
  output logic                   o_parity_err,
  output logic                   o_overrun
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] C_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
`ifdef UART_RX_PARITY_EN
  localparam rx_state_t AFTER_DATA = PARITY;
`else
  localparam rx_state_t AFTER_DATA = STOP;
`endif
  rx_state_t              r_state;
  logic [CW-1:0]          r_cnt;
  logic [2:0]             r_idx;
  logic [UART_DATA_W-1:0] r_sh;
  logic [UART_DATA_W-1:0] r_data;
  logic                   r_valid;
  logic                   r_fe;
  logic                   r_ov;
  logic                   w_rx_s;
  logic                   w_last;
`ifdef UART_RX_PARITY_EN
  logic                   r_pe;
  logic                   r_mis;
`endif
  uart_rx_sync u_sync (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_d    (i_rx),
    .o_q    (w_rx_s)
  );
  assign w_last = r_cnt == C_LAST;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_sh    <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_fe    <= 1'b0;
      r_ov    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_pe    <= 1'b0;
      r_mis   <= 1'b0;
`endif
    end else begin
      r_fe <= 1'b0;
      r_ov <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_pe <= 1'b0;
`endif
      if (r_valid && i_ready) r_valid <= 1'b0;
      case (r_state)
        // The detect cycle already counts as the first cycle of the start bit.
        IDLE: if (!w_rx_s) begin
          r_state <= START;
          r_cnt   <= CW'(1);
        end
        START: if (r_cnt == C_HALF) begin
          r_cnt   <= '0;
          r_idx   <= '0;
          r_state <= w_rx_s ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
          r_mis   <= 1'b0;
`endif
        end else r_cnt <= r_cnt + 1'b1;
        DATA: if (w_last) begin
          r_cnt <= '0;
          r_sh  <= {w_rx_s, r_sh[UART_DATA_W-1:1]};
          r_idx <= r_idx + 1'b1;
          if (r_idx == 3'd7) r_state <= AFTER_DATA;
        end else r_cnt <= r_cnt + 1'b1;
`ifdef UART_RX_PARITY_EN
        PARITY: if (w_last) begin
          r_cnt   <= '0;
          r_mis   <= w_rx_s ^ (^r_sh);
          r_state <= STOP;
        end else r_cnt <= r_cnt + 1'b1;
`endif
        STOP: if (w_last) begin
          r_cnt   <= '0;
          r_state <= w_rx_s ? IDLE : BREAK;
          if (!w_rx_s) r_fe <= 1'b1;
`ifdef UART_RX_PARITY_EN
          else if (r_mis) r_pe <= 1'b1;
`endif
          else if (!r_valid || i_ready) begin
            r_data  <= r_sh;
            r_valid <= 1'b1;
          end else r_ov <= 1'b1;
        end else r_cnt <= r_cnt + 1'b1;
        BREAK: if (w_rx_s) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  assign o_data      = r_data;
  assign o_valid     = r_valid;
  assign o_frame_err = r_fe;
  assign o_overrun   = r_ov;
`ifdef UART_RX_PARITY_EN
  assign o_parity_err = r_pe;
`else
  assign o_parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed table plus timed corner sequences for uart_rx.
module tb_uart_rx;
  localparam int C = 16;
`ifdef UART_RX_PARITY_EN
  localparam int LAT = 169;
`else
  localparam int LAT = 153;
`endif
  typedef struct {
    logic [7:0] b;
    logic       stop;
    logic       flip;
    logic [7:0] exp_d;
    int         exp_v;
    int         exp_fe;
    int         exp_pe;
  } vec_t;
  logic clk = 1'b0, rst_n = 1'b0, rx = 1'b1, ready = 1'b1;
  logic [7:0] data;
  logic valid, frame_err, parity_err, overrun;
  int cyc = 0, n_pass = 0, n_tot = 0;
  int n_v = 0, n_fe = 0, n_pe = 0, n_ov = 0;
  logic [7:0] acc = 8'h00;
  vec_t vt[$];
  uart_rx #(.CLKS_PER_BIT(C)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_rx        (rx),
    .o_data      (data),
    .o_valid     (valid),
    .i_ready     (ready),
    .o_frame_err (frame_err),
    .o_parity_err(parity_err),
    .o_overrun   (overrun)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (valid && ready) begin
      n_v <= n_v + 1;
      acc <= data;
    end
    n_fe <= n_fe + int'(frame_err);
    n_pe <= n_pe + int'(parity_err);
    n_ov <= n_ov + int'(overrun);
  end
  initial begin
    #5ms;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1);
  end
  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d required %0d", nm, act, exp);
  endtask
  task automatic step();
    @(negedge clk);
    #1;
  endtask
  task automatic rx_bit(input logic v);
    rx = v;
    repeat (C) @(negedge clk);
  endtask
  task automatic send(input logic [7:0] b, input logic stop, input logic flip);
    @(negedge clk);
    rx_bit(1'b0);
    for (int i = 0; i < 8; i++) rx_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    rx_bit(^b ^ flip);
`endif
    rx_bit(stop);
  endtask
  initial begin
    int v0, f0, p0, o0, e0;
    vt.push_back('{8'h00, 1'b1, 1'b0, 8'h00, 1, 0, 0});
    vt.push_back('{8'hFF, 1'b1, 1'b0, 8'hFF, 1, 0, 0});
    vt.push_back('{8'h81, 1'b1, 1'b0, 8'h81, 1, 0, 0});
    vt.push_back('{8'h3C, 1'b0, 1'b0, 8'h00, 0, 1, 0});
    vt.push_back('{8'h6E, 1'b1, 1'b0, 8'h6E, 1, 0, 0});
`ifdef UART_RX_PARITY_EN
    vt.push_back('{8'h07, 1'b1, 1'b1, 8'h00, 0, 0, 1});
    vt.push_back('{8'h07, 1'b1, 1'b0, 8'h07, 1, 0, 0});
`endif
    repeat (3) step();
    chk("rst_valid", int'(valid), 0);
    chk("rst_data", int'(data), 0);
    chk("rst_flags", int'({frame_err, parity_err, overrun}), 0);
    rst_n = 1'b1;
    repeat (2 * C) step();
    chk("idle_valid", int'(valid), 0);
    // A5 with exact latency and one-cycle valid under ready=1
    fork
      send(8'hA5, 1'b1, 1'b0);
      begin
        wait (rx == 1'b0);
        e0 = cyc + 1;
        wait (cyc == e0 + LAT - 1);
        step();
        chk("a5_before", int'(valid), 0);
        step();
        chk("a5_valid", int'(valid), 1);
        chk("a5_data", int'(data), 'hA5);
        step();
        chk("a5_one_cycle", int'(valid), 0);
      end
    join
    rx = 1'b1;
    repeat (2 * C) step();
    chk("a5_flags", n_fe + n_pe + n_ov, 0);
    chk("a5_count", n_v, 1);
    for (int k = 0; k < vt.size(); k++) begin
      v0 = n_v; f0 = n_fe; p0 = n_pe;
      send(vt[k].b, vt[k].stop, vt[k].flip);
      rx = 1'b1;
      repeat (2 * C) step();
      chk($sformatf("vec%0d_valid", k), n_v - v0, vt[k].exp_v);
      chk($sformatf("vec%0d_ferr", k), n_fe - f0, vt[k].exp_fe);
      chk($sformatf("vec%0d_perr", k), n_pe - p0, vt[k].exp_pe);
      if (vt[k].exp_v != 0) chk($sformatf("vec%0d_data", k), int'(acc), int'(vt[k].exp_d));
    end
    // short low glitch is a false start
    v0 = n_v; f0 = n_fe + n_pe + n_ov;
    @(negedge clk);
    rx = 1'b0;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    repeat (3 * C) step();
    chk("glitch_valid", n_v - v0, 0);
    chk("glitch_flags", n_fe + n_pe + n_ov - f0, 0);
    // stop bit low followed by a long break
    v0 = n_v; f0 = n_fe;
    send(8'h3C, 1'b0, 1'b0);
    repeat (40 * C) @(negedge clk);
    chk("break_ferr", n_fe - f0, 1);
    chk("break_valid", n_v - v0, 0);
    rx = 1'b1;
    repeat (2 * C) step();
    send(8'h5A, 1'b1, 1'b0);
    repeat (2 * C) step();
    chk("after_break_data", int'(acc), 'h5A);
    chk("after_break_count", n_v - v0, 1);
    // overrun with the consumer stalled
    @(posedge clk); #2 ready = 1'b0;
    o0 = n_ov;
    send(8'h11, 1'b1, 1'b0);
    send(8'h22, 1'b1, 1'b0);
    repeat (2 * C) step();
    chk("ovr_valid", int'(valid), 1);
    chk("ovr_data", int'(data), 'h11);
    chk("ovr_pulse", n_ov - o0, 1);
    @(posedge clk); #2 ready = 1'b1;
    step();
    step();
    chk("ovr_drain_valid", int'(valid), 0);
    chk("ovr_drain_data", int'(acc), 'h11);
    // consume and load on the same edge
    @(posedge clk); #2 ready = 1'b0;
    send(8'h44, 1'b1, 1'b0);
    repeat (2 * C) step();
    v0 = n_v; o0 = n_ov;
    fork
      send(8'h55, 1'b1, 1'b0);
      begin
        wait (rx == 1'b0);
        e0 = cyc + 1;
        wait (cyc == e0 + LAT - 1);
        #2 ready = 1'b1;
        wait (cyc == e0 + LAT);
        #2 ready = 1'b0;
        step();
        chk("same_edge_valid", int'(valid), 1);
        chk("same_edge_data", int'(data), 'h55);
      end
    join
    rx = 1'b1;
    repeat (2 * C) step();
    chk("same_edge_ovr", n_ov - o0, 0);
    chk("same_edge_acc", int'(acc), 'h44);
    chk("same_edge_cnt", n_v - v0, 1);
    // asynchronous reset in the middle of the data bits
    v0 = n_v; f0 = n_fe + n_pe + n_ov;
    @(negedge clk);
    rx = 1'b0;
    repeat (C) @(negedge clk);
    rx = 1'b1;
    repeat (C) @(negedge clk);
    rx = 1'b0;
    repeat (C / 2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", int'(valid), 0);
    chk("mid_rst_data", int'(data), 0);
    rx = 1'b1;
    ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12 * C) step();
    chk("mid_rst_silent", n_v - v0 + n_fe + n_pe + n_ov - f0, 0);
    send(8'hC3, 1'b1, 1'b0);
    repeat (2 * C) step();
    chk("post_rst_data", int'(acc), 'hC3);
    chk("post_rst_count", n_v - v0, 1);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
